// File: rtl/filter_ctrl_pkg.sv
// filter_ctrl_pkg: register indices, CTRL/STATUS bit positions and AXI response codes for filter_ctrl_regs
package filter_ctrl_pkg;
  localparam int CTRL_IDX = 0;
  localparam int STATUS_IDX = 1;
  localparam int VERSION_IDX = 2;
  localparam int COEF_BASE_IDX = 3;
  localparam int CTRL_START = 0;
  localparam int CTRL_ENABLE = 1;
  localparam int CTRL_SOFT_RST = 2;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
endpackage

// File: rtl/filter_ctrl_strb_reg.sv
// filter_ctrl_strb_reg: DATA_WIDTH register (clk, rst, we, strb per byte, d in, q out) updating only strobed bytes
module filter_ctrl_strb_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [DATA_WIDTH-1:0]   d,
  output logic [DATA_WIDTH-1:0]   q
);
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH/8; i++)
      if (rst) q[i*8 +: 8] <= '0;
      else if (we && strb[i]) q[i*8 +: 8] <= d[i*8 +: 8];
  end
endmodule

// File: rtl/filter_ctrl_regs.sv
// filter_ctrl_regs: AXI4-Lite slave (ACLK/ARESET, AW/W/B/AR/R channels) exposing CTRL, STATUS, VERSION and NUM_COEF coefficients to the filter core
module filter_ctrl_regs
  import filter_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_COEF   = 8,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] VERSION    = 32'h0002_0000
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic                           ctrl_enable_o,
  output logic                           ctrl_start_o,
  output logic                           ctrl_soft_rst_o,
  output logic [NUM_COEF*DATA_WIDTH-1:0] coef_o,
  output logic                           coef_update_o,
  input  logic                           core_busy_i,
  input  logic                           core_done_i
);
  localparam int LSB = $clog2(DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH-1:0] END_IDX = ADDR_WIDTH'(COEF_BASE_IDX + NUM_COEF);
  logic live, aw_full, w_full, done, commit, ctrl_we, w1c;
  logic [ADDR_WIDTH-1:0] aw_addr, widx, ridx;
  logic [DATA_WIDTH-1:0] w_data, ctrl_q, rd_val;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic [NUM_COEF-1:0] coef_we;
  assign s_axi_awready = live & ~aw_full;
  assign s_axi_wready = live & ~w_full;
  assign s_axi_arready = live & ~s_axi_rvalid;
  assign commit = aw_full & w_full & ~s_axi_bvalid;
  assign widx = aw_addr >> LSB;
  assign ridx = s_axi_araddr >> LSB;
  assign ctrl_we = commit & (widx == ADDR_WIDTH'(CTRL_IDX));
  assign w1c = commit & (widx == ADDR_WIDTH'(STATUS_IDX)) & w_strb[0] & w_data[STATUS_DONE];
  assign ctrl_enable_o = ctrl_q[CTRL_ENABLE];
  filter_ctrl_strb_reg #(.DATA_WIDTH(DATA_WIDTH)) u_ctrl (
    .clk(ACLK), .rst(ARESET), .we(ctrl_we), .strb(w_strb),
    .d(w_data & DATA_WIDTH'(1 << CTRL_ENABLE)), .q(ctrl_q)
  );
  for (genvar k = 0; k < NUM_COEF; k++) begin : g_coef
    assign coef_we[k] = commit & (widx == ADDR_WIDTH'(COEF_BASE_IDX + k));
    filter_ctrl_strb_reg #(.DATA_WIDTH(DATA_WIDTH)) u_coef (
      .clk(ACLK), .rst(ARESET), .we(coef_we[k]), .strb(w_strb),
      .d(w_data), .q(coef_o[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end
  always_comb begin
    rd_val = ridx == ADDR_WIDTH'(CTRL_IDX)    ? ctrl_q :
             ridx == ADDR_WIDTH'(STATUS_IDX)  ? DATA_WIDTH'({done, core_busy_i}) :
             ridx == ADDR_WIDTH'(VERSION_IDX) ? DATA_WIDTH'(VERSION) : '0;
    for (int j = 0; j < NUM_COEF; j++)
      if (ridx == ADDR_WIDTH'(COEF_BASE_IDX + j)) rd_val = coef_o[j*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      live <= 1'b0;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp <= OKAY;
      s_axi_rdata <= '0;
      done <= 1'b0;
      ctrl_start_o <= 1'b0;
      ctrl_soft_rst_o <= 1'b0;
      coef_update_o <= 1'b0;
    end else begin
      live <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_full <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end else if (commit) aw_full <= 1'b0;
      if (s_axi_wvalid && s_axi_wready) begin
        w_full <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end else if (commit) w_full <= 1'b0;
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp <= widx < END_IDX ? OKAY : SLVERR;
      end else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      ctrl_start_o <= ctrl_we & w_strb[0] & w_data[CTRL_START];
      ctrl_soft_rst_o <= ctrl_we & w_strb[0] & w_data[CTRL_SOFT_RST];
      coef_update_o <= |coef_we;
      done <= core_done_i | (done & ~w1c);
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata <= rd_val;
        s_axi_rresp <= ridx < END_IDX ? OKAY : SLVERR;
      end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_filter_ctrl_regs.sv
// tb_filter_ctrl_regs: directed self-checking bench for filter_ctrl_regs with default parameters
module tb_filter_ctrl_regs;
  logic ACLK = 0, ARESET = 1;
  logic [7:0] s_axi_awaddr = 0, s_axi_araddr = 0;
  logic s_axi_awvalid = 0, s_axi_awready, s_axi_wvalid = 0, s_axi_wready;
  logic [31:0] s_axi_wdata = 0, s_axi_rdata;
  logic [3:0] s_axi_wstrb = 0;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic s_axi_bvalid, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_arready, s_axi_rvalid, s_axi_rready = 0;
  logic ctrl_enable_o, ctrl_start_o, ctrl_soft_rst_o, coef_update_o;
  logic [255:0] coef_o;
  logic core_busy_i = 0, core_done_i = 0;
  int n_chk = 0, n_pass = 0, n_start = 0, n_soft = 0, n_upd = 0;
  logic [31:0] exp_coef [8];
  logic [31:0] rd;
  logic [1:0] rsp;
  int w_t, s0, f0, u0;

  filter_ctrl_regs dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .ctrl_enable_o(ctrl_enable_o), .ctrl_start_o(ctrl_start_o), .ctrl_soft_rst_o(ctrl_soft_rst_o),
    .coef_o(coef_o), .coef_update_o(coef_update_o),
    .core_busy_i(core_busy_i), .core_done_i(core_done_i)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (ctrl_start_o) n_start <= n_start + 1;
    if (ctrl_soft_rst_o) n_soft <= n_soft + 1;
    if (coef_update_o) n_upd <= n_upd + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input bit pulse_done, output logic [1:0] resp, output int wt);
    int t;
    bit awd, wd, hsa, hsw;
    t = 0; awd = 0; wd = 0; wt = -1;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(awd && wd) && t < 50) begin
      s_axi_awvalid = !awd && t >= (lead > 0 ? lead : 0);
      s_axi_wvalid = !wd && t >= (lead < 0 ? -lead : 0);
      hsa = s_axi_awvalid && s_axi_awready;
      hsw = s_axi_wvalid && s_axi_wready;
      tick();
      if (hsa) awd = 1;
      if (hsw) begin wd = 1; wt = t; end
      t++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    check("aw_w_accept", 64'(awd && wd), 64'd1);
    core_done_i = pulse_done;
    s_axi_bready = 1;
    t = 0;
    while (!s_axi_bvalid && t < 50) begin tick(); core_done_i = 0; t++; end
    core_done_i = 0;
    check("b_valid", 64'(s_axi_bvalid), 64'd1);
    resp = s_axi_bresp;
    tick();
    s_axi_bready = 0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int t;
    bit hs;
    t = 0; hs = 0;
    s_axi_araddr = a; s_axi_arvalid = 1;
    while (!hs && t < 50) begin hs = s_axi_arready; tick(); t++; end
    s_axi_arvalid = 0;
    check("ar_accept", 64'(hs), 64'd1);
    s_axi_rready = 1;
    t = 0;
    while (!s_axi_rvalid && t < 50) begin tick(); t++; end
    check("r_valid", 64'(s_axi_rvalid), 64'd1);
    d = s_axi_rdata; r = s_axi_rresp;
    tick();
    s_axi_rready = 0;
  endtask

  task automatic check_coefs(input string tag);
    for (int k = 0; k < 8; k++) check(tag, 64'(coef_o[k*32 +: 32]), 64'(exp_coef[k]));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) exp_coef[k] = 0;
    repeat (3) tick();
    check("rst_awready", 64'(s_axi_awready), 0);
    check("rst_wready", 64'(s_axi_wready), 0);
    check("rst_arready", 64'(s_axi_arready), 0);
    check("rst_bvalid", 64'(s_axi_bvalid), 0);
    check("rst_rvalid", 64'(s_axi_rvalid), 0);
    check("rst_pulses", 64'({ctrl_start_o, ctrl_soft_rst_o, coef_update_o, ctrl_enable_o}), 0);
    ARESET = 0;
    tick();
    for (int i = 0; i < 11; i++) begin
      axi_read(8'(i * 4), rd, rsp);
      check($sformatf("rst_rd_%0d", i), 64'(rd), i == 2 ? 64'h0002_0000 : 64'd0);
      check($sformatf("rst_rresp_%0d", i), 64'(rsp), 0);
    end
    u0 = n_upd;
    axi_write(8'h0C, 32'hDEADBEEF, 4'hF, 0, 0, rsp, w_t);
    check("coef0_full_bresp", 64'(rsp), 0);
    check("coef0_full_upd", 64'(n_upd - u0), 1);
    axi_write(8'h0C, 32'h0000_1234, 4'h3, 0, 0, rsp, w_t);
    check("coef0_strb_upd", 64'(n_upd - u0), 2);
    exp_coef[0] = 32'hDEAD1234;
    axi_read(8'h0C, rd, rsp);
    check("coef0_strb_rd", 64'(rd), 64'hDEAD1234);
    check("coef0_out", 64'(coef_o[31:0]), 64'hDEAD1234);
    axi_write(8'h10, 32'hA5A5A5A5, 4'hF, 4, 0, rsp, w_t);
    check("wfirst_bresp", 64'(rsp), 0);
    check("wfirst_wready", 64'(w_t), 0);
    axi_read(8'h10, rd, rsp);
    check("wfirst_rd", 64'(rd), 64'hA5A5A5A5);
    axi_write(8'h10, 32'h5A5A5A5A, 4'hF, -4, 0, rsp, w_t);
    check("awfirst_bresp", 64'(rsp), 0);
    check("awfirst_wt", 64'(w_t), 4);
    axi_read(8'h10, rd, rsp);
    check("awfirst_rd", 64'(rd), 64'h5A5A5A5A);
    axi_write(8'h10, 32'h0F0F0F0F, 4'hF, 0, 0, rsp, w_t);
    check("both_bresp", 64'(rsp), 0);
    exp_coef[1] = 32'h0F0F0F0F;
    axi_read(8'h10, rd, rsp);
    check("both_rd", 64'(rd), 64'h0F0F0F0F);
    axi_write(8'h28, 32'h77777777, 4'hF, 0, 0, rsp, w_t);
    exp_coef[7] = 32'h77777777;
    check("coef7_bresp", 64'(rsp), 0);
    axi_read(8'h28, rd, rsp);
    check("coef7_rd", 64'(rd), 64'h77777777);
    u0 = n_upd;
    axi_write(8'h2C, 32'hFFFFFFFF, 4'hF, 0, 0, rsp, w_t);
    check("oor_bresp", 64'(rsp), 2);
    check("oor_no_upd", 64'(n_upd - u0), 0);
    check_coefs("oor_coefs");
    axi_read(8'h2C, rd, rsp);
    check("oor_rresp", 64'(rsp), 2);
    check("oor_rdata", 64'(rd), 0);
    axi_write(8'h08, 32'hFFFFFFFF, 4'hF, 0, 0, rsp, w_t);
    check("ver_wr_bresp", 64'(rsp), 0);
    axi_read(8'h08, rd, rsp);
    check("ver_wr_rd", 64'(rd), 64'h0002_0000);
    s0 = n_start; f0 = n_soft;
    axi_write(8'h00, 32'h7, 4'hF, 0, 0, rsp, w_t);
    repeat (3) tick();
    check("ctrl7_start", 64'(n_start - s0), 1);
    check("ctrl7_soft", 64'(n_soft - f0), 1);
    check("ctrl7_enable", 64'(ctrl_enable_o), 1);
    axi_read(8'h00, rd, rsp);
    check("ctrl7_rd", 64'(rd), 2);
    check_coefs("softrst_keeps");
    axi_write(8'h00, 32'h1, 4'h0, 0, 0, rsp, w_t);
    repeat (3) tick();
    check("ctrl_nostrb_start", 64'(n_start - s0), 1);
    check("ctrl_nostrb_enable", 64'(ctrl_enable_o), 1);
    core_done_i = 1;
    tick();
    core_done_i = 0;
    axi_read(8'h04, rd, rsp);
    check("done_set", 64'(rd), 2);
    core_busy_i = 1;
    axi_read(8'h04, rd, rsp);
    check("busy_done", 64'(rd), 3);
    core_busy_i = 0;
    axi_write(8'h04, 32'h2, 4'hF, 0, 1, rsp, w_t);
    axi_read(8'h04, rd, rsp);
    check("done_set_wins", 64'(rd), 2);
    axi_write(8'h04, 32'h2, 4'hF, 0, 0, rsp, w_t);
    axi_read(8'h04, rd, rsp);
    check("done_w1c", 64'(rd), 0);
    u0 = n_upd;
    s_axi_awaddr = 8'h14; s_axi_wdata = 32'h11111111; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    tick();
    check("hold_b_rise", 64'(s_axi_bvalid), 1);
    s_axi_wdata = 32'h22222222;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check("hold_bvalid", 64'(s_axi_bvalid), 1);
      check("hold_no_commit", 64'(coef_o[2*32 +: 32]), 64'h11111111);
      tick();
    end
    s_axi_bready = 1;
    tick();
    tick();
    check("second_b", 64'(s_axi_bvalid), 1);
    check("second_commit", 64'(coef_o[2*32 +: 32]), 64'h22222222);
    tick();
    s_axi_bready = 0;
    tick();
    check("hold_upd_count", 64'(n_upd - u0), 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
